// File: rtl/axi_reg_cmd_sequencer.sv
// rtl/axi_reg_cmd_sequencer.sv - register command stream to single-beat AXI4 write/read sequencer
// One command in flight at a time; each command yields exactly one response, timeouts included.

module axi_reg_cmd_sequencer #(
    parameter int ADDR_WIDTH     = 40,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic                    busy,
    output logic [31:0]             done_count,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int              STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]      AXSIZE     = 3'($clog2(STRB_WIDTH));
    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TMO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0]   TMO_LAST   = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_AR   = 3'd3,
        S_RD   = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    wlast_q, wlast_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    busy_q, busy_d;
    logic [31:0]             done_count_q, done_count_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

    logic tmo_hit;
    logic aw_done;
    logic w_done;
    logic abort;
    logic unused_rlast;

    assign unused_rlast = m_axi_rlast;

    always_comb begin
        state_d       = state_q;
        tmo_cnt_d     = tmo_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        done_count_d  = done_count_q;
        aw_done       = 1'b0;
        w_done        = 1'b0;
        abort         = 1'b0;

        tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);
        if (TMO_EN && (state_q inside {S_WR, S_WB, S_AR, S_RD})) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    tmo_cnt_d   = '0;
                    if (cmd_write) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently; a channel already done counts as done.
                aw_done = !awvalid_q || m_axi_awready;
                w_done  = !wvalid_q  || m_axi_wready;
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q  && m_axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = S_WB;
                    bready_d = 1'b1;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_WB: begin
                if (m_axi_bvalid) begin
                    bready_d      = 1'b0;
                    state_d       = S_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_RD: begin
                if (m_axi_rvalid) begin
                    rready_d      = 1'b0;
                    state_d       = S_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_resp_d    = m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count_q + 32'd1;
                    state_d      = S_IDLE;
                    cmd_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timed-out command abandons the slave and reports SLVERR with no data.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            state_d       = S_RSP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end

        busy_d  = (state_d != S_IDLE);
        wlast_d = wvalid_d;
        id_d    = ID_WIDTH'(1);
        size_d  = AXSIZE;
        burst_d = 2'b01;
        wstrb_d = '1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            tmo_cnt_q     <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            done_count_q  <= '0;
            id_q          <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            wlast_q       <= wlast_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            done_count_q  <= done_count_d;
            id_q          <= id_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            wstrb_q       <= wstrb_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;
    assign done_count    = done_count_q;

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = size_q;
    assign m_axi_awburst = burst_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = burst_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
